data_ram: RTL and testbench

DATA_RAM -- requirements
Module: data_ram

---
 rtl/data_ram_pkg.sv | 47 ++++
 rtl/data_ram_array.sv | 27 ++
 rtl/data_ram.sv | 131 +++++++++++++
 tb/tb_data_ram.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared definitions for the data RAM: access-size encodings, controller
// state type and the byte-lane helpers used by the store and load paths.
package data_ram_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Byte-lane write enables for a store of the given size at byte offset lo.
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: store_be = 4'b0001 << lo;
      SIZE_HALF: store_be = lo[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: store_be = 4'b1111;
      default:   store_be = 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data so every candidate lane carries it.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_BYTE: store_data = {4{wdata[7:0]}};
      SIZE_HALF: store_data = {2{wdata[15:0]}};
      default:   store_data = wdata;
    endcase
  endfunction

  // Pull the addressed lanes out of a memory word, right-align and extend.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lo, input logic sgn);
    logic [31:0] sh;
    sh = word >> {lo, 3'b000};
    case (size)
      SIZE_BYTE: load_extract = {{24{sgn & sh[7]}}, sh[7:0]};
      SIZE_HALF: load_extract = {{16{sgn & sh[15]}}, sh[15:0]};
      SIZE_WORD: load_extract = word;
      default:   load_extract = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/data_ram_array.sv
// DEPTH x 32 storage with one synchronous read/write port and byte enables.
// Reads return the word as it was before any write on the same edge.
module data_ram_array #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [3:0]       i_be,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Byte-masked write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end
    r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_ram.sv
// Byte-addressable data RAM controller. After reset it clears every word
// (INIT) and then serves one load/store per cycle with a one-cycle response.
// Handshake: a request is taken on a rising edge where req_valid and
// req_ready are both 1; each taken request yields exactly one rsp_valid
// pulse on the following cycle, with no response backpressure.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_fault;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_rdata;

  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic             r_load;
  logic [1:0]       r_size;
  logic [1:0]       r_lo;
  logic             r_signed;

  assign req_ready = (r_state == ST_RUN);
  assign busy      = (r_state == ST_INIT);
  assign dbg_state = r_state;
  assign w_accept  = req_valid & req_ready;

  // Misaligned, illegal-size or out-of-range accesses fault.
  assign w_fault = (req_size == SIZE_BAD)
                 | ((req_size == SIZE_HALF) & req_addr[0])
                 | ((req_size == SIZE_WORD) & (|req_addr[1:0]))
                 | (|(req_addr >> (IDX_W + 2)));

  // Next-state logic: INIT ends after the last word has been cleared.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_cnt == IDX_W'(DEPTH - 1)) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // State register and clear counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_cnt <= r_cnt + IDX_W'(1);
    end
  end

  // Array port mux: INIT clear has the port, otherwise the request does.
  // Writes are suppressed on a reset edge so reset never alters memory.
  always_comb begin
    w_idx   = req_addr[IDX_W+1:2];
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    if (r_state == ST_INIT) begin
      w_idx   = r_cnt;
      w_be    = 4'b1111;
    end else if (w_accept && req_we && !w_fault) begin
      w_be    = store_be(req_size, req_addr[1:0]);
      w_wdata = store_data(req_size, req_wdata);
    end
    if (reset) w_be = 4'b0000;
  end

  data_ram_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_idx   (w_idx),
    .i_be    (w_be),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // Response pipeline: remember what was accepted so the next cycle can
  // extract load data from the array's registered read word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_load      <= 1'b0;
      r_size      <= SIZE_BYTE;
      r_lo        <= 2'b00;
      r_signed    <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      r_rsp_err   <= w_accept & w_fault;
      r_load      <= w_accept & ~req_we & ~w_fault;
      r_size      <= req_size;
      r_lo        <= req_addr[1:0];
      r_signed    <= req_signed;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_load ? load_extract(w_rdata, r_size, r_lo, r_signed) : 32'h0;

endmodule

// File: tb/tb_data_ram.sv
// Testbench for data_ram (DEPTH=256): byte-level memory model plus directed
// vectors with hand-computed expectations.
module tb_data_ram;
  import data_ram_pkg::*;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b10;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;
  state_t            dbg_state;

  always #5 clk = ~clk;

  data_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Memory is a flat byte array; every request is judged by its byte
  // address, size in bytes and the memory bound.
  logic [7:0]  mem_b [DEPTH*4];
  bit          m_known = 0;
  int          m_init_left = 0;
  logic        m_valid = 0;
  logic        m_err = 0;
  logic [31:0] m_rdata = 0;

  task automatic model_access();
    longint unsigned a;
    int n;
    logic [31:0] v;
    a = req_addr;
    n = (req_size == 2'b00) ? 1 : (req_size == 2'b01) ? 2 : (req_size == 2'b10) ? 4 : 0;
    m_valid = 1;
    if (n == 0 || (a % n) != 0 || a >= DEPTH * 4) begin
      m_err = 1;
      m_rdata = 0;
      return;
    end
    if (req_we) begin
      for (int i = 0; i < n; i++) mem_b[a + i] = req_wdata[8*i +: 8];
      m_rdata = 0;
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mem_b[a + i];
      if (req_signed && n < 4 && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
      m_rdata = v;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_known = 1;
      m_init_left = DEPTH;
      m_valid = 0;
      m_err = 0;
      m_rdata = 0;
      for (int i = 0; i < DEPTH * 4; i++) mem_b[i] = 8'h00;
    end else if (m_known) begin
      m_valid = 0;
      m_err = 0;
      m_rdata = 0;
      if (m_init_left > 0) m_init_left--;
      else if (req_valid) model_access();
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_known) begin
      chk("req_ready", 32'(req_ready), 32'(m_init_left == 0));
      chk("busy", 32'(busy), 32'(m_init_left != 0));
      chk("dbg_state", 32'(dbg_state), (m_init_left == 0) ? 32'(ST_RUN) : 32'(ST_INIT));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
      chk("rsp_rdata", rsp_rdata, m_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; presents one request for the next rising edge and
  // returns at the following negedge, where its response is visible.
  task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic wait_ready(input string name, output int cycles);
    cycles = 0;
    while (!req_ready && cycles < 400) begin
      cycles++;
      @(negedge clk);
    end
    if (!req_ready) chk({name, "_timeout"}, 32'(req_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    // Reset with a word load of 0x0 held pending throughout.
    req_valid = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    wait_ready("init", n);
    chk("init_cycles", 32'(n), 32'd256);
    chk("init_done_busy", 32'(busy), 32'd0);

    // All words read back zero.
    for (int i = 0; i < DEPTH; i++) begin
      send(1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0);
      if (i == 0 || i == DEPTH - 1) chk("sweep_zero", rsp_rdata, 32'h0);
    end

    // Word store then partial loads.
    send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("store_rdata", rsp_rdata, 32'h0);
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("load_w10", rsp_rdata, 32'hDEAD_BEEF);
    send(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    chk("load_sb13", rsp_rdata, 32'hFFFF_FFDE);
    send(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    chk("load_uh10", rsp_rdata, 32'h0000_BEEF);
    send(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    chk("load_sh12", rsp_rdata, 32'hFFFF_DEAD);

    // Byte store merges into one lane.
    send(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA);
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("load_w10_merged", rsp_rdata, 32'hDEAD_AAEF);
    send(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    chk("load_ub11", rsp_rdata, 32'h0000_00AA);

    // Faults.
    send(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
    chk("fault_half_err", 32'(rsp_err), 32'd1);
    chk("fault_half_rdata", rsp_rdata, 32'h0);
    send(1'b1, 2'b10, 1'b0, 32'h400, 32'h1);
    chk("fault_range_err", 32'(rsp_err), 32'd1);
    send(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    chk("after_range_w0", rsp_rdata, 32'h0);
    chk("after_range_err", 32'(rsp_err), 32'd0);
    send(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    chk("fault_size_err", 32'(rsp_err), 32'd1);
    chk("fault_size_rdata", rsp_rdata, 32'h0);

    // Back-to-back store then load of the same word.
    send(1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678);
    chk("b2b_first_valid", 32'(rsp_valid), 32'd1);
    send(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("b2b_second_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_second_rdata", rsp_rdata, 32'h1234_5678);

    // Reset on the accept cycle of a load.
    reset      = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_size   = 2'b10;
    req_addr   = 32'h10;
    @(negedge clk);
    chk("rst_load_no_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_load_busy", 32'(busy), 32'd1);
    reset     = 1'b0;
    req_valid = 1'b0;
    wait_ready("reinit", n);
    chk("reinit_cycles", 32'(n), 32'd256);
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("reinit_w10", rsp_rdata, 32'h0);
    send(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("reinit_w20", rsp_rdata, 32'h0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
